// File: rtl/frame_loader.sv
// frame_loader: hunts for a sync byte in a byte stream, packs the next 192
// payload bytes into 64 24-bit pixels written to a pixel_column_mux, then
// requests a frame swap once the mux reports ready.
module frame_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        mux_ready,
  output logic        write_en,
  output logic [5:0]  pixel_addr,
  output logic [23:0] pixel_value,
  output logic        send_frame,
  output logic        busy,
  output logic        frame_err,
  output logic [7:0]  frames_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [5:0]  pix_q, pix_d;
  logic [15:0] asm_q, asm_d;
  logic [15:0] tmo_q, tmo_d;
  logic        write_en_q, write_en_d;
  logic [5:0]  addr_q, addr_d;
  logic [23:0] value_q, value_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  frames_q, frames_d;
  logic [15:0] tmo_inc;

  assign tmo_inc = tmo_q + 16'd1;

  // The pixel-63 write is still on the bus during the first COMMIT cycle;
  // holding the swap off until it is gone keeps the last write ahead of it.
  assign send_frame  = (state_q == ST_COMMIT) && mux_ready && !write_en_q;
  assign busy        = (state_q != ST_IDLE);
  assign write_en    = write_en_q;
  assign pixel_addr  = addr_q;
  assign pixel_value = value_q;
  assign frame_err   = frame_err_q;
  assign frames_done = frames_q;

  // Next-state, byte packing, timeout and commit decisions.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pix_d       = pix_q;
    asm_d       = asm_q;
    tmo_d       = tmo_q;
    write_en_d  = 1'b0;
    addr_d      = addr_q;
    value_d     = value_q;
    frame_err_d = 1'b0;
    frames_d    = frames_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LOAD;
          phase_d = '0;
          pix_d   = '0;
          tmo_d   = '0;
        end
      end
      ST_LOAD: begin
        if (rx_valid) begin
          tmo_d = '0;
          asm_d = {asm_q[7:0], rx_data};
          if (phase_q == 2'd2) begin
            phase_d    = '0;
            write_en_d = 1'b1;
            addr_d     = pix_q;
            value_d    = {asm_q, rx_data};
            pix_d      = pix_q + 6'd1;
            if (pix_q == 6'd63) state_d = ST_COMMIT;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TIMEOUT_CYCLES) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        if (send_frame) begin
          state_d  = ST_IDLE;
          frames_d = frames_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      pix_q       <= '0;
      asm_q       <= '0;
      tmo_q       <= '0;
      write_en_q  <= 1'b0;
      addr_q      <= '0;
      value_q     <= '0;
      frame_err_q <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pix_q       <= pix_d;
      asm_q       <= asm_d;
      tmo_q       <= tmo_d;
      write_en_q  <= write_en_d;
      addr_q      <= addr_d;
      value_q     <= value_d;
      frame_err_q <= frame_err_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Testbench for frame_loader: scoreboard of expected pixel writes plus
// pulse monitors for send_frame and frame_err.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mux_ready;
  logic        write_en;
  logic [5:0]  pixel_addr;
  logic [23:0] pixel_value;
  logic        send_frame;
  logic        busy;
  logic        frame_err;
  logic [7:0]  frames_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_sends  = 0;
  int unsigned n_ferrs  = 0;
  logic        prev_send = 1'b0;
  logic        prev_ferr = 1'b0;
  logic [29:0] exp_q[$];
  logic [29:0] exp_w;
  logic [7:0]  exp_frames;

  frame_loader #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(16'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .mux_ready(mux_ready),
    .write_en(write_en),
    .pixel_addr(pixel_addr),
    .pixel_value(pixel_value),
    .send_frame(send_frame),
    .busy(busy),
    .frame_err(frame_err),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (write_en) begin
        check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("wr_addr", 32'(pixel_addr), 32'(exp_w[29:24]));
          check("wr_value", 32'(pixel_value), 32'(exp_w[23:0]));
        end
      end
      if (send_frame) begin
        n_sends++;
        check("send_ready", 32'(mux_ready), 32'd1);
        check("send_no_wr", 32'(write_en), 32'd0);
        check("send_1cyc", 32'(prev_send), 32'd0);
      end
      if (frame_err) begin
        n_ferrs++;
        check("ferr_1cyc", 32'(prev_ferr), 32'd0);
      end
      prev_send = send_frame;
      prev_ferr = frame_err;
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Sends one pixel as three bytes and queues the write it must produce.
  task automatic send_pix(input logic [5:0] idx, input logic [23:0] v);
    send_byte(v[23:16]);
    send_byte(v[15:8]);
    exp_q.push_back({idx, v});
    send_byte(v[7:0]);
  endtask

  // mode 0: pixel k = {k, ~k, 5A}; mode 1: random with embedded sync bytes.
  task automatic send_frame_payload(input int unsigned mode);
    logic [7:0]  k;
    logic [23:0] v;
    send_byte(8'hA5);
    for (int unsigned i = 0; i < 64; i++) begin
      k = 8'(i);
      if (mode == 0) v = {k, ~k, 8'h5A};
      else begin
        v = 24'($urandom);
        if (i % 3 == 0) v[23:16] = 8'hA5;
        if (i % 5 == 1) v[7:0]   = 8'hA5;
      end
      send_pix(6'(i), v);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; mux_ready = 1'b1;
    exp_frames = '0;
    idle(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr", 32'(write_en), 32'd0);
    check("rst_addr", 32'(pixel_addr), 32'd0);
    check("rst_value", 32'(pixel_value), 32'd0);
    check("rst_send", 32'(send_frame), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_frames", 32'(frames_done), 32'd0);
    rst = 1'b0;
    idle(2);

    // Nominal frame.
    send_frame_payload(0);
    exp_frames++;
    idle(4);
    check("nom_sends", n_sends, 32'd1);
    check("nom_frames", 32'(frames_done), 32'(exp_frames));
    check("nom_busy", 32'(busy), 32'd0);
    check("nom_sb", exp_q.size(), 32'd0);

    // Garbage before sync.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    idle(2);
    check("garb_busy", 32'(busy), 32'd0);
    send_frame_payload(1);
    exp_frames++;
    idle(4);
    check("garb_frames", 32'(frames_done), 32'(exp_frames));
    check("garb_sends", n_sends, 32'd2);

    // Timeout, with a byte landing exactly on the boundary cycle.
    send_byte(8'hA5);
    send_pix(6'd0, 24'h112233);
    idle(15);
    send_pix(6'd1, 24'h445566);
    send_pix(6'd2, 24'h778899);
    send_byte(8'hAA);
    check("tmo_boundary_err", n_ferrs, 32'd0);
    idle(15);
    check("tmo_busy_before", 32'(busy), 32'd1);
    idle(1);
    check("tmo_busy_after", 32'(busy), 32'd0);
    check("tmo_ferr_level", 32'(frame_err), 32'd1);
    idle(3);
    check("tmo_ferrs", n_ferrs, 32'd1);
    check("tmo_sends", n_sends, 32'd2);
    check("tmo_frames", 32'(frames_done), 32'(exp_frames));
    check("tmo_sb", exp_q.size(), 32'd0);

    // Ready wait: bytes arriving in COMMIT are dropped, no timeout there.
    mux_ready = 1'b0;
    send_frame_payload(1);
    for (int unsigned i = 0; i < 20; i++) send_byte((i % 2 == 0) ? 8'hA5 : 8'h3C);
    check("rdy_wait_sends", n_sends, 32'd2);
    check("rdy_wait_busy", 32'(busy), 32'd1);
    check("rdy_wait_ferrs", n_ferrs, 32'd1);
    mux_ready = 1'b1;
    exp_frames++;
    idle(4);
    check("rdy_sends", n_sends, 32'd3);
    check("rdy_frames", 32'(frames_done), 32'(exp_frames));
    check("rdy_busy", 32'(busy), 32'd0);

    // Sync bytes in the COMMIT cycles, including the one leaving COMMIT.
    send_frame_payload(0);
    send_byte(8'hA5);
    send_byte(8'hA5);
    exp_frames++;
    idle(2);
    check("lastsync_busy", 32'(busy), 32'd0);
    check("lastsync_frames", 32'(frames_done), 32'(exp_frames));

    // Mid-frame reset after 100 payload bytes.
    send_byte(8'hA5);
    for (int unsigned i = 0; i < 33; i++) send_pix(6'(i), 24'($urandom));
    send_byte(8'h77);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_wr", 32'(write_en), 32'd0);
    check("mrst_addr", 32'(pixel_addr), 32'd0);
    check("mrst_value", 32'(pixel_value), 32'd0);
    check("mrst_frames", 32'(frames_done), 32'd0);
    check("mrst_sb", exp_q.size(), 32'd0);
    idle(1);
    rst = 1'b0;
    exp_frames = '0;
    idle(1);
    send_frame_payload(1);
    exp_frames++;
    idle(3);
    check("mrst_frame1", 32'(frames_done), 32'd1);

    // Commit 255 more frames: counter wraps to 0.
    for (int unsigned f = 0; f < 255; f++) begin
      send_frame_payload(1);
      exp_frames++;
      idle(2);
      if (f == 253) check("wrap_255", 32'(frames_done), 32'd255);
    end
    check("wrap_zero", 32'(frames_done), 32'(exp_frames));
    check("end_sb", exp_q.size(), 32'd0);
    check("end_ferrs", n_ferrs, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
